fp_div_mant_core: RTL and testbench

- Iterative single-precision mantissa/exponent divider. It sits directly upstream of the division rounding stage.
- Accepts two IEEE-754 binary32 operands and computes the sign, the biased exponent and a truncated 23-bit normalized fraction of a/b, one quotient bit per clock.
- Fraction and exponent outputs feed the rounding stage's mantissa and exponent inputs unchanged.

---
 rtl/fp_div_mant_core.sv | 214 +++++++++++++++++++++
 tb/tb_fp_div_mant_core.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_mant_core.sv
// fp_div_mant_core: iterative binary32 divider front end.
// Produces the sign, the biased exponent and a truncated normalized fraction
// of a/b using restoring division, one quotient bit per clock. The results
// are passed unchanged to the division rounding stage.
module fp_div_mant_core #(
    parameter int FRAC_W = 23,
    parameter int EXP_W  = 8,
    parameter int BIAS   = 127
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              q_sign,
    output logic [EXP_W-1:0]  q_exp,
    output logic [FRAC_W-1:0] q_frac,
    output logic              dz,
    output logic              ovf,
    output logic              unf
);

    // Quotient bits produced: one integer bit, FRAC_W fraction bits and one
    // extra bit so the fraction stays complete when the leading bit is 0.
    localparam int ITER   = FRAC_W + 2;
    localparam int MANT_W = FRAC_W + 1;
    localparam int R_W    = MANT_W + 1;
    localparam int CNT_W  = $clog2(ITER);
    localparam int E_W    = EXP_W + 2;
    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_r;
    logic [EXP_W-1:0]    ea_r;
    logic [EXP_W-1:0]    eb_r;
    logic [MANT_W-1:0]   mb_r;
    logic [R_W-1:0]      r_r;
    logic [ITER-1:0]     q_r;
    logic [CNT_W-1:0]    cnt_r;

    logic [EXP_W-1:0]    a_exp_s;
    logic [EXP_W-1:0]    b_exp_s;
    logic                a_zero_s;
    logic                b_zero_s;
    logic                ab_special_s;
    logic                accept_s;
    logic                r_ge_s;
    logic [R_W-1:0]      r_sel_s;
    logic [R_W-1:0]      r_nxt_s;
    logic [ITER-1:0]     q_nxt_s;
    logic signed [E_W-1:0] e_s;
    logic                e_ovf_s;
    logic                e_unf_s;
    logic [FRAC_W-1:0]   frac_norm_s;

    // Operand classification and the accept handshake.
    always_comb begin
        a_exp_s      = a[30:23];
        b_exp_s      = b[30:23];
        a_zero_s     = (a_exp_s == {EXP_W{1'b0}});
        b_zero_s     = (b_exp_s == {EXP_W{1'b0}});
        ab_special_s = (a_exp_s == EXP_MAX) || (b_exp_s == EXP_MAX);
        accept_s     = in_valid && in_ready;
    end

    // One restoring-division step: subtract when the remainder covers the
    // divisor, then shift the remainder and append the new quotient bit.
    always_comb begin
        r_ge_s = (r_r >= {1'b0, mb_r});
        if (r_ge_s) begin
            r_sel_s = r_r - {1'b0, mb_r};
        end else begin
            r_sel_s = r_r;
        end
        r_nxt_s = {r_sel_s[R_W-2:0], 1'b0};
        q_nxt_s = {q_r[ITER-2:0], r_ge_s};
    end

    // Exponent adjust and fraction selection from the quotient's leading bit.
    always_comb begin
        e_s = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r})
            + $signed(E_W'(BIAS - 1)) + $signed({{(E_W-1){1'b0}}, q_r[ITER-1]});
        e_ovf_s = !e_s[E_W-1] && (e_s[E_W-2:0] >= {1'b0, EXP_MAX});
        e_unf_s = e_s[E_W-1] || (e_s == {E_W{1'b0}});
        if (q_r[ITER-1]) begin
            frac_norm_s = q_r[ITER-2:1];
        end else begin
            frac_norm_s = q_r[ITER-3:0];
        end
    end

    // Control FSM with registered handshake, result and flag outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q_sign    <= 1'b0;
            q_exp     <= {EXP_W{1'b0}};
            q_frac    <= {FRAC_W{1'b0}};
            dz        <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            ea_r      <= {EXP_W{1'b0}};
            eb_r      <= {EXP_W{1'b0}};
            mb_r      <= {MANT_W{1'b0}};
            r_r       <= {R_W{1'b0}};
            q_r       <= {ITER{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        q_sign   <= a[31] ^ b[31];
                        ea_r     <= a_exp_s;
                        eb_r     <= b_exp_s;
                        mb_r     <= {1'b1, b[22:0]};
                        in_ready <= 1'b0;
                        if (b_zero_s) begin
                            dz        <= 1'b1;
                            ovf       <= 1'b0;
                            unf       <= 1'b0;
                            q_exp     <= EXP_MAX;
                            q_frac    <= {FRAC_W{1'b0}};
                            out_valid <= 1'b1;
                            state_r   <= DONE;
                        end else if (ab_special_s) begin
                            dz        <= 1'b0;
                            ovf       <= 1'b1;
                            unf       <= 1'b0;
                            q_exp     <= EXP_MAX;
                            q_frac    <= {FRAC_W{1'b0}};
                            out_valid <= 1'b1;
                            state_r   <= DONE;
                        end else if (a_zero_s) begin
                            dz        <= 1'b0;
                            ovf       <= 1'b0;
                            unf       <= 1'b0;
                            q_exp     <= {EXP_W{1'b0}};
                            q_frac    <= {FRAC_W{1'b0}};
                            out_valid <= 1'b1;
                            state_r   <= DONE;
                        end else begin
                            r_r     <= {1'b0, 1'b1, a[22:0]};
                            q_r     <= {ITER{1'b0}};
                            cnt_r   <= {CNT_W{1'b0}};
                            state_r <= CALC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    r_r   <= r_nxt_s;
                    q_r   <= q_nxt_s;
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_W'(ITER - 1)) begin
                        state_r <= NORM;
                    end else begin
                        state_r <= CALC;
                    end
                end
                NORM: begin
                    dz <= 1'b0;
                    if (e_ovf_s) begin
                        q_exp  <= EXP_MAX;
                        q_frac <= {FRAC_W{1'b0}};
                        ovf    <= 1'b1;
                        unf    <= 1'b0;
                    end else if (e_unf_s) begin
                        q_exp  <= {EXP_W{1'b0}};
                        q_frac <= {FRAC_W{1'b0}};
                        ovf    <= 1'b0;
                        unf    <= 1'b1;
                    end else begin
                        q_exp  <= e_s[EXP_W-1:0];
                        q_frac <= frac_norm_s;
                        ovf    <= 1'b0;
                        unf    <= 1'b0;
                    end
                    out_valid <= 1'b1;
                    state_r   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        dz        <= 1'b0;
                        ovf       <= 1'b0;
                        unf       <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_mant_core.sv
// Directed testbench for fp_div_mant_core with hand-computed quotients.
module tb_fp_div_mant_core;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic        q_sign;
    logic [7:0]  q_exp;
    logic [22:0] q_frac;
    logic        dz;
    logic        ovf;
    logic        unf;

    int errors = 0;
    int checks = 0;

    fp_div_mant_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_sign    (q_sign),
        .q_exp     (q_exp),
        .q_frac    (q_frac),
        .dz        (dz),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand pair for a single edge and count edges (accept edge
    // is number 1) until out_valid is seen, bounded at 40.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, output int lat);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Complete the output handshake and check the block returns to idle.
    task automatic release_result(input string tag);
        logic [7:0] exp_hold;
        exp_hold = q_exp;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || {dz, ovf, unf} !== 3'b000 || q_exp !== exp_hold) begin
            errors++;
            $display("FAIL %s_release: in_ready=%b out_valid=%b flags=%b q_exp=%0d, want 1 0 000 %0d",
                     tag, in_ready, out_valid, {dz, ovf, unf}, q_exp, exp_hold);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 32'h0;
        b = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        checks++;
        if ({q_sign, q_exp, q_frac, dz, ovf, unf} !== 35'h0) begin
            errors++;
            $display("FAIL reset_data: sign=%b exp=%h frac=%h flags=%b, want all 0",
                     q_sign, q_exp, q_frac, {dz, ovf, unf});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Normal-path division with a full result check and handshake.
    task automatic test_normal(input string tag, input logic [31:0] av, input logic [31:0] bv,
                               input logic s, input logic [7:0] e, input logic [22:0] f,
                               input logic [2:0] flags);
        int lat;
        run_op(av, bv, lat);
        checks++;
        if (lat !== 27) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges, want 27", tag, lat);
        end
        checks++;
        if (q_sign !== s || q_exp !== e || q_frac !== f || {dz, ovf, unf} !== flags) begin
            errors++;
            $display("FAIL %s_result: sign=%b exp=%0d frac=%h flags=%b, want %b %0d %h %b",
                     tag, q_sign, q_exp, q_frac, {dz, ovf, unf}, s, e, f, flags);
        end
        release_result(tag);
    endtask

    // Special operands finish on the accept edge.
    task automatic test_special(input string tag, input logic [31:0] av, input logic [31:0] bv,
                                input logic s, input logic [7:0] e, input logic [2:0] flags);
        int lat;
        run_op(av, bv, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges, want 1", tag, lat);
        end
        checks++;
        if (q_sign !== s || q_exp !== e || q_frac !== 23'h0 || {dz, ovf, unf} !== flags) begin
            errors++;
            $display("FAIL %s_result: sign=%b exp=%0d frac=%h flags=%b, want %b %0d 0 %b",
                     tag, q_sign, q_exp, q_frac, {dz, ovf, unf}, s, e, flags);
        end
        release_result(tag);
    endtask

    task automatic test_backpressure();
        int lat;
        a = 32'h3F800000;
        b = 32'h3F800000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        repeat (5) begin
            @(posedge clk); #1;
            lat++;
        end
        // Operands offered mid-calculation must be ignored.
        a = 32'h40C00000;
        b = 32'hC0000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        lat++;
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 27 || q_sign !== 1'b0 || q_exp !== 8'd127 || q_frac !== 23'h0) begin
            errors++;
            $display("FAIL bp_ignore: lat=%0d sign=%b exp=%0d frac=%h, want 27 0 127 0",
                     lat, q_sign, q_exp, q_frac);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || q_exp !== 8'd127 ||
                q_frac !== 23'h0 || q_sign !== 1'b0 || {dz, ovf, unf} !== 3'b000) begin
                errors++;
                $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b exp=%0d frac=%h, want 1 0 127 0",
                         i, out_valid, in_ready, q_exp, q_frac);
            end
        end
        // New operands held during the handshake edge must not be taken then.
        a = 32'h3F800000;
        b = 32'h00000000;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_handshake: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || dz !== 1'b1 || q_exp !== 8'd255) begin
            errors++;
            $display("FAIL bp_next_accept: out_valid=%b dz=%b exp=%0d, want 1 1 255", out_valid, dz, q_exp);
        end
        release_result("bp");
    endtask

    task automatic test_reset_midcalc();
        a = 32'h40C00000;
        b = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || q_exp !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid_async: in_ready=%b out_valid=%b exp=%0d, want 1 0 0", in_ready, out_valid, q_exp);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || {dz, ovf, unf} !== 3'b000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_stale: out_valid=%b flags=%b in_ready=%b, want 0 000 1",
                     out_valid, {dz, ovf, unf}, in_ready);
        end
        test_normal("rst_6div2", 32'h40C00000, 32'h40000000, 1'b0, 8'd128, 23'h400000, 3'b000);
    endtask

    initial begin
        test_reset();
        test_normal("one_div_one", 32'h3F800000, 32'h3F800000, 1'b0, 8'd127, 23'h000000, 3'b000);
        test_normal("six_div_m2",  32'h40C00000, 32'hC0000000, 1'b1, 8'd128, 23'h400000, 3'b000);
        test_normal("one_div_3",   32'h3F800000, 32'h40400000, 1'b0, 8'd125, 23'h2AAAAA, 3'b000);
        test_special("div_zero",   32'h3F800000, 32'h00000000, 1'b0, 8'd255, 3'b100);
        test_normal("exp_ovf",     32'h7F000000, 32'h00800000, 1'b0, 8'd255, 23'h000000, 3'b010);
        test_normal("exp_unf",     32'h00800000, 32'h7F000000, 1'b0, 8'd0,   23'h000000, 3'b001);
        test_special("nan_in",     32'h7FC00000, 32'h3F800000, 1'b0, 8'd255, 3'b010);
        test_special("zero_num",   32'h80000000, 32'h3F800000, 1'b1, 8'd0,   3'b000);
        test_backpressure();
        test_reset_midcalc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
